// File: rtl/avalon_host_master_if.sv
// Host-side command, beat source, completion and Avalon-MM bus bundle
// for the accelerator loader initiator.
interface avalon_host_master_if #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 10
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [DATA_W-1:0]  cmd_wdata;
  logic [BURST_W-1:0] cmd_len;
  logic [DATA_W-1:0]  src_data;
  logic               src_valid;
  logic               src_ready;
  logic               rsp_valid;
  logic [DATA_W-1:0]  rsp_rdata;
  logic               rsp_error;
  logic [ADDR_W-1:0]  address;
  logic               write;
  logic               read;
  logic [DATA_W-1:0]  writedata;
  logic               beginbursttransfer;
  logic [BURST_W-1:0] burstcount;
  logic               waitrequest;
  logic [DATA_W-1:0]  readdata;
  logic               readdatavalid;
  logic [1:0]         response;
  logic               writeresponsevalid;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_len,
    input  src_data, src_valid,
    input  waitrequest, readdata, readdatavalid,
    input  response, writeresponsevalid,
    output cmd_ready, src_ready,
    output rsp_valid, rsp_rdata, rsp_error,
    output address, write, read, writedata,
    output beginbursttransfer, burstcount
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_len,
    output src_data, src_valid,
    output waitrequest, readdata, readdatavalid,
    output response, writeresponsevalid,
    input  cmd_ready, src_ready,
    input  rsp_valid, rsp_rdata, rsp_error,
    input  address, write, read, writedata,
    input  beginbursttransfer, burstcount
  );
endinterface

// File: rtl/avalon_host_master.sv
// Avalon-MM initiator: single write, single read and burst write
// commands in, one completion per command out.
module avalon_host_master #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 10,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic n_rst,
  avalon_host_master_if.master bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, WR, RD_REQ, RD_WAIT, BURST, RESP
  } state_t;

  state_t state, state_nx;

  logic               rdy_q, err_q;
  logic               wr_q, rd_q, bbt_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdat_q, rdat_q;
  logic [BURST_W-1:0] bcnt_q, beat_q, ld_q;
  logic [TW-1:0]      tmo_q;

  logic fire, acc, rerr, bad_cmd;
  logic tmo_hit, ld, last;

  assign fire    = bus.cmd_valid & bus.cmd_ready;
  assign acc     = (wr_q | rd_q) & ~bus.waitrequest;
  assign rerr    = bus.response != 2'b00;
  assign bad_cmd = (bus.cmd_op == 2'b11) |
                   (bus.cmd_len == '0);
  assign tmo_hit = tmo_q == TW'(TIMEOUT - 1);
  // a new beat may enter the holding register as the old one leaves
  assign ld      = (state == BURST) & bus.src_valid &
                   (~wr_q | acc) & (ld_q < bcnt_q);
  assign last    = acc & (beat_q == bcnt_q - 1'b1);

  assign bus.cmd_ready          = rdy_q & (state == IDLE);
  assign bus.src_ready          = ld;
  assign bus.rsp_valid          = state == RESP;
  assign bus.rsp_error          = (state == RESP) & err_q;
  assign bus.rsp_rdata          = (state == RESP) ? rdat_q : '0;
  assign bus.address            = addr_q;
  assign bus.write              = wr_q;
  assign bus.read               = rd_q;
  assign bus.writedata          = wdat_q;
  assign bus.beginbursttransfer = bbt_q;
  assign bus.burstcount         = bcnt_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (fire) begin
        if (bad_cmd)                  state_nx = RESP;
        else if (bus.cmd_op == 2'b00) state_nx = WR;
        else if (bus.cmd_op == 2'b01) state_nx = RD_REQ;
        else                          state_nx = BURST;
      end
      WR: if (acc | tmo_hit) state_nx = RESP;
      RD_REQ: begin
        if (acc)
          state_nx = bus.readdatavalid ? RESP : RD_WAIT;
        else if (tmo_hit)
          state_nx = RESP;
      end
      RD_WAIT:
        if (bus.readdatavalid | tmo_hit) state_nx = RESP;
      BURST: begin
        if (last)
          state_nx = RESP;
        else if (wr_q & bus.waitrequest & tmo_hit)
          state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rdy_q  <= 1'b0;
      err_q  <= 1'b0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      bbt_q  <= 1'b0;
      addr_q <= '0;
      wdat_q <= '0;
      rdat_q <= '0;
      bcnt_q <= '0;
      beat_q <= '0;
      ld_q   <= '0;
      tmo_q  <= '0;
    end else begin
      rdy_q <= 1'b1;
      bbt_q <= 1'b0;
      unique case (state)
        IDLE: if (fire) begin
          addr_q <= bus.cmd_addr;
          wdat_q <= bus.cmd_wdata;
          rdat_q <= '0;
          err_q  <= bad_cmd;
          tmo_q  <= '0;
          beat_q <= '0;
          ld_q   <= '0;
          bcnt_q <= (bus.cmd_op == 2'b10) ?
                    bus.cmd_len : BURST_W'(1);
          wr_q   <= ~bad_cmd & (bus.cmd_op == 2'b00);
          rd_q   <= ~bad_cmd & (bus.cmd_op == 2'b01);
        end
        WR: begin
          if (acc) begin
            wr_q  <= 1'b0;
            err_q <= rerr;
          end else if (tmo_hit) begin
            wr_q  <= 1'b0;
            err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        RD_REQ: begin
          if (acc) begin
            rd_q  <= 1'b0;
            tmo_q <= '0;
            if (bus.readdatavalid) begin
              rdat_q <= bus.readdata;
              err_q  <= rerr;
            end
          end else if (tmo_hit) begin
            rd_q  <= 1'b0;
            err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        RD_WAIT: begin
          if (bus.readdatavalid) begin
            rdat_q <= bus.readdata;
            err_q  <= rerr;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        BURST: begin
          if (acc) begin
            beat_q <= beat_q + 1'b1;
            tmo_q  <= '0;
            if (rerr) err_q <= 1'b1;
          end else if (wr_q) begin
            if (tmo_hit) err_q <= 1'b1;
            else         tmo_q <= tmo_q + 1'b1;
          end
          if (bus.writeresponsevalid & rerr)
            err_q <= 1'b1;
          if (ld) begin
            wdat_q <= bus.src_data;
            wr_q   <= 1'b1;
            ld_q   <= ld_q + 1'b1;
            bbt_q  <= ld_q == '0;
          end else if (acc | tmo_hit) begin
            wr_q <= 1'b0;
          end
        end
        RESP:    ;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_avalon_host_master.sv
// Directed bench for avalon_host_master: vector table of single
// operations plus hand sequences for bursts and mid-burst reset.
module tb_avalon_host_master;
  logic tb_clk = 1'b0;
  logic n_rst  = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 tb_clk = ~tb_clk;

  avalon_host_master_if rif ();

  avalon_host_master dut (
    .clk   (tb_clk),
    .n_rst (n_rst),
    .bus   (rif)
  );

  typedef struct {
    logic [1:0]  op;
    logic [12:0] addr;
    logic [31:0] wdata;
    logic [9:0]  len;
    int          wait_n;
    int          rdv_dly;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          exp_hi;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               nm, got, exp);
    end
  endtask

  task automatic idle_in();
    rif.cmd_valid          = 1'b0;
    rif.cmd_op             = 2'b00;
    rif.cmd_addr           = '0;
    rif.cmd_wdata          = '0;
    rif.cmd_len            = '0;
    rif.src_data           = '0;
    rif.src_valid          = 1'b0;
    rif.waitrequest        = 1'b0;
    rif.readdata           = '0;
    rif.readdatavalid      = 1'b0;
    rif.response           = 2'b00;
    rif.writeresponsevalid = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op,
                       input logic [12:0] a,
                       input logic [31:0] d,
                       input logic [9:0] len);
    int t = 0;
    @(negedge tb_clk);
    while (rif.cmd_ready !== 1'b1 && t < 50) begin
      @(negedge tb_clk);
      t++;
    end
    check("cmd_ready_wait", {31'b0, rif.cmd_ready}, 32'd1);
    rif.cmd_valid = 1'b1;
    rif.cmd_op    = op;
    rif.cmd_addr  = a;
    rif.cmd_wdata = d;
    rif.cmd_len   = len;
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int cyc = 0;
    int hi = 0;
    int lat = -1;
    int wcnt = v.wait_n;
    int rcnt = 0;
    int bad = 0;
    logic        got_err = 1'b0;
    logic [31:0] got_rd  = '0;
    issue(v.op, v.addr, v.wdata, v.len);
    while (lat < 0 && cyc < 600) begin
      @(negedge tb_clk);
      rif.cmd_valid = 1'b0;
      if (rif.rsp_valid) begin
        lat     = cyc;
        got_err = rif.rsp_error;
        got_rd  = rif.rsp_rdata;
      end
      if (rif.write && rif.read) bad++;
      if (rif.write || rif.read) begin
        hi++;
        if (rif.address !== v.addr) bad++;
        if (rif.burstcount !== 10'd1) bad++;
        if (rif.write && rif.writedata !== v.wdata) bad++;
      end
      rif.waitrequest   = 1'b0;
      rif.readdatavalid = 1'b0;
      rif.response      = 2'b00;
      rif.readdata      = '0;
      if (rif.write || rif.read) begin
        if (wcnt > 0) begin
          rif.waitrequest = 1'b1;
          wcnt--;
        end else if (rif.write) begin
          rif.response = v.resp;
        end else if (v.rdv_dly == 0) begin
          rif.readdatavalid = 1'b1;
          rif.readdata      = v.rdata;
          rif.response      = v.resp;
        end else begin
          rcnt = v.rdv_dly;
        end
      end else if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin
          rif.readdatavalid = 1'b1;
          rif.readdata      = v.rdata;
          rif.response      = v.resp;
        end
      end
      cyc++;
    end
    idle_in();
    check($sformatf("v%0d_latency", k), lat, v.exp_lat);
    check($sformatf("v%0d_bus_cycles", k), hi, v.exp_hi);
    check($sformatf("v%0d_rsp_error", k),
          {31'b0, got_err}, {31'b0, v.exp_err});
    check($sformatf("v%0d_rsp_rdata", k), got_rd, v.exp_rdata);
    check($sformatf("v%0d_bus_values", k), bad, 0);
    @(negedge tb_clk);
    check($sformatf("v%0d_ready_after", k),
          {30'b0, rif.cmd_ready, rif.rsp_valid}, 32'd2);
  endtask

  task automatic run_burst(input string nm,
                           input logic [12:0] a,
                           input int len,
                           input int err_beat,
                           input bit gaps,
                           input logic exp_err);
    int nx = 0;
    int ai = 0;
    int bbt_n = 0;
    int rsp_n = 0;
    int bad = 0;
    int t = 0;
    bit wr_seen = 1'b0;
    logic got_err = 1'b0;
    issue(2'b10, a, 32'h0, 10'(len));
    while (rsp_n == 0 && t < 20000) begin
      @(negedge tb_clk);
      rif.cmd_valid = 1'b0;
      t++;
      if (rif.rsp_valid) begin
        rsp_n++;
        got_err = rif.rsp_error;
      end
      if (rif.read) bad++;
      if (rif.beginbursttransfer) begin
        bbt_n++;
        if (!rif.write || wr_seen) bad++;
      end
      if (rif.write) begin
        if (!wr_seen && !rif.beginbursttransfer) bad++;
        wr_seen = 1'b1;
        if (rif.address !== a) bad++;
        if (rif.burstcount !== 10'(len)) bad++;
      end
      rif.waitrequest = rif.write && gaps &&
                        ($urandom_range(0, 4) == 0);
      rif.response = (rif.write && !rif.waitrequest &&
                      ai == err_beat) ? 2'b10 : 2'b00;
      rif.src_valid = (nx < len) &&
                      (!gaps || $urandom_range(0, 3) != 0);
      rif.src_data = 32'(2 * nx);
      #1;
      if (rif.src_ready) nx++;
      if (rif.write && !rif.waitrequest) begin
        check($sformatf("%s_beat%0d", nm, ai),
              rif.writedata, 32'(2 * ai));
        ai++;
      end
    end
    idle_in();
    check({nm, "_rsp_count"}, rsp_n, 1);
    check({nm, "_beats_accepted"}, ai, len);
    check({nm, "_beats_loaded"}, nx, len);
    check({nm, "_bbt_cycles"}, bbt_n, 1);
    check({nm, "_bus_values"}, bad, 0);
    check({nm, "_rsp_error"}, {31'b0, got_err}, {31'b0, exp_err});
    @(negedge tb_clk);
    check({nm, "_ready_after"},
          {30'b0, rif.cmd_ready, rif.rsp_valid}, 32'd2);
  endtask

  initial begin
    int ai;
    int t;
    int rsp_seen;
    vt[0] = '{2'b00, 13'h62B, 32'h0000000F, 10'd1, 2, 0,
              32'h0, 2'b00, 3, 3, 1'b0, 32'h0};
    vt[1] = '{2'b01, 13'h62B, 32'h0, 10'd1, 0, 3,
              32'h0000000F, 2'b00, 1, 4, 1'b0, 32'h0000000F};
    vt[2] = '{2'b01, 13'hFFF, 32'h0, 10'd1, 1, 0,
              32'hA5A55A5A, 2'b10, 2, 2, 1'b1, 32'hA5A55A5A};
    vt[3] = '{2'b00, 13'h001, 32'hDEADBEEF, 10'd1, 0, 0,
              32'h0, 2'b01, 1, 1, 1'b1, 32'h0};
    vt[4] = '{2'b00, 13'h100, 32'h12345678, 10'd1, 1000, 0,
              32'h0, 2'b00, 255, 255, 1'b1, 32'h0};
    vt[5] = '{2'b11, 13'h200, 32'h0, 10'd1, 0, 0,
              32'h0, 2'b00, 0, 0, 1'b1, 32'h0};
    vt[6] = '{2'b00, 13'h300, 32'h55, 10'd0, 0, 0,
              32'h0, 2'b00, 0, 0, 1'b1, 32'h0};
    vt[7] = '{2'b01, 13'hABC, 32'h0, 10'd1, 3, 1,
              32'h12345678, 2'b00, 4, 5, 1'b0, 32'h12345678};
    vt[8] = '{2'b01, 13'h010, 32'h0, 10'd1, 0, 1000,
              32'h0, 2'b00, 1, 256, 1'b1, 32'h0};
    vt[9] = '{2'b10, 13'h020, 32'h0, 10'd0, 0, 0,
              32'h0, 2'b00, 0, 0, 1'b1, 32'h0};

    idle_in();
    n_rst = 1'b0;
    repeat (3) @(negedge tb_clk);
    check("rst_cmd_ready", {31'b0, rif.cmd_ready}, 32'd0);
    check("rst_ctrl",
          {26'b0, rif.write, rif.read, rif.beginbursttransfer,
           rif.src_ready, rif.rsp_valid, rif.rsp_error}, 32'd0);
    check("rst_address", {19'b0, rif.address}, 32'd0);
    check("rst_burstcount", {22'b0, rif.burstcount}, 32'd0);
    check("rst_writedata", rif.writedata, 32'd0);
    check("rst_rsp_rdata", rif.rsp_rdata, 32'd0);
    n_rst = 1'b1;

    for (int k = 0; k < 10; k++) run_vec(k, vt[k]);

    run_burst("burst784", 13'h000, 784, -1, 1'b1, 1'b0);
    run_burst("burst5err", 13'h040, 5, 2, 1'b0, 1'b1);

    issue(2'b10, 13'h1AB, 32'h0, 10'd300);
    ai = 0;
    t  = 0;
    while (ai < 100 && t < 1000) begin
      @(negedge tb_clk);
      rif.cmd_valid   = 1'b0;
      rif.waitrequest = 1'b0;
      rif.src_valid   = 1'b1;
      rif.src_data    = 32'h1000 + 32'(t);
      #1;
      if (rif.write && !rif.waitrequest) ai++;
      t++;
    end
    check("rstmid_reached_beat100", ai, 100);
    check("rstmid_write_before", {31'b0, rif.write}, 32'd1);
    n_rst = 1'b0;
    #1;
    check("rstmid_ctrl",
          {26'b0, rif.write, rif.read, rif.beginbursttransfer,
           rif.src_ready, rif.rsp_valid, rif.cmd_ready}, 32'd0);
    check("rstmid_address", {19'b0, rif.address}, 32'd0);
    check("rstmid_burstcount", {22'b0, rif.burstcount}, 32'd0);
    check("rstmid_writedata", rif.writedata, 32'd0);
    rsp_seen = 0;
    repeat (3) begin
      @(negedge tb_clk);
      if (rif.rsp_valid) rsp_seen++;
    end
    idle_in();
    n_rst = 1'b1;
    repeat (3) begin
      @(negedge tb_clk);
      if (rif.rsp_valid) rsp_seen++;
    end
    check("rstmid_no_rsp", rsp_seen, 0);
    run_vec(10, vt[0]);
    run_vec(11, vt[1]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog expired");
  end
endmodule
